bcd_serial_converter: RTL and testbench
=======================================

# bcd_serial_converter

Sequential double-dabble stage between the KPN output FIFO and the LCD/seven-segment writers. It pops one 16-bit binary token from the upstream FIFO, converts it to five packed BCD digits over WIDTH shift cycles, and presents the result with a valid/ack handshake. The last result stays on `output_1` so the display consumers always see a stable value.

## Interface
Parameters:
- `WIDTH`, 16: binary token width.
- `DIGITS`, 5: BCD digits produced. Elaboration-time check requires DIGITS*4 ≥ ceil(WIDTH·log10 2)·4, and DIGITS ≥ 5 for WIDTH=16.

Ports:
- `clk`  in  1  KPN clock; all state on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `fifo_empty`  in  1  upstream FIFO empty flag.
- `entry_1`  in  WIDTH  upstream FIFO head word (show-ahead; valid while `fifo_empty`=0).
- `rd`  out  1  one-cycle pop strobe to upstream FIFO.
- `output_1`  out  DIGITS*4  packed BCD, most significant digit in the top nibble.
- `valid`  out  1  result on `output_1` not yet acknowledged.
- `ack`  in  1  consumer has taken the result.
- `busy`  out  1  conversion in progress.

## Operation
- FSM states are IDLE, SHIFT, and DONE.
- **IDLE.** `rd` = !`fifo_empty`. On a cycle with `rd`=1:
  - Capture `entry_1` into the binary shift register.
  - Clear the BCD accumulator and load the iteration counter with WIDTH.
  - Go to SHIFT.
- **SHIFT.** Each cycle runs one double-dabble step:
  - Every 4-bit digit ≥ 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - The counter decrements. When the counter reaches 1 and its step completes, go to DONE.
- **DONE.**
  - Copy the accumulator to `output_1` on DONE entry. `valid`=1.
  - Stay in DONE while `ack`=0. `rd`=0 and `output_1` is frozen.
  - With `ack`=1 and `fifo_empty`=1: clear `valid` and go to IDLE.
  - With `ack`=1 and `fifo_empty`=0: assert `rd` in the same cycle, capture `entry_1`, go straight to SHIFT, and clear `valid`. This is back-to-back operation.
- `ack` while `valid`=0 is ignored.
- `output_1` keeps the last converted value indefinitely. It changes only on DONE entry or reset.
- `rd` is purely a function of state, `fifo_empty` and `ack`. It is never asserted while `fifo_empty`=1.
- Digit adjust arithmetic is 4-bit, with no carry between digits before the shift. The maximum input 2^WIDTH−1 must fit DIGITS digits without truncation.

## Timing
- Reset values: `rd`=0, `valid`=0, `busy`=0, `output_1`=0. State is IDLE and the counter is 0.
- Reset asserted mid-conversion or in DONE:
  - The next edge forces the reset values and the token is discarded.
  - The FIFO pop already issued is not replayed.
- Latency: `rd` high in cycle T, `valid` high from cycle T+WIDTH+1 (T+17 at default).
- `busy`=1 from cycle T+1 through the last SHIFT cycle.
- Throughput with `ack` tied high and the FIFO never empty: one token per WIDTH+1 cycles. DONE lasts one cycle, overlapping the next `rd`.
- Simultaneous `ack` and a new FIFO word in DONE: pop happens in that cycle. No IDLE bubble.
- FIFO becoming non-empty during SHIFT or DONE: the word is not popped until the handshake allows it.

## Structure
- Shared package `kpn_pkg`:
  - Constants `KPN_DATA_WIDTH`=16 and `KPN_BCD_DIGITS`=5.
  - State enum `bcd_state_t` {IDLE, SHIFT, DONE}.
  - The `top_module_lcd` data wires and this block use the package constants.
- Sub-module `bcd_digit_adjust`: combinational, 4-bit in to 4-bit out (+3 if ≥5). Instantiated DIGITS times in a generate loop.
- Everything else is one always block for the FSM/datapath plus continuous `rd`/`busy` assigns.

## Test plan
- Reset then idle: hold `rst_n`=0 for 3 cycles with `fifo_empty`=1. Required: `rd`, `valid`, `busy` stay 0 and `output_1`=0x00000 through 50 cycles.
- Single conversion: push 1234, `ack` held 0.
  - `rd` pulses once in cycle T.
  - `valid`=1 at T+17 with `output_1`=0x01234.
  - `valid` and `output_1` are held for 20 cycles with no further `rd`.
- Boundaries: tokens 0, 9, 10, 65535. Required outputs: 0x00000, 0x00009, 0x00010, 0x65535.
- Back-to-back: FIFO preloaded with 100, 200, 300 and `ack` tied 1.
  - `rd` pulses at T, T+17, T+34.
  - Outputs are 0x00100, 0x00200, 0x00300 at T+17, T+34, T+51.
- Reset mid-operation: assert `rst_n`=0 at T+8 of a conversion of 4321.
  - Next edge: all outputs 0, no `valid`.
  - After release, the next FIFO word 55 converts to 0x00055.
- Scoreboard over 1000 random tokens with random `ack` stalls and random empty gaps:
  - `output_1` equals a reference decimal conversion.
  - The `rd` count equals the `valid`-rise count.

Source files
------------

// File: rtl/bcd_serial_converter_pkg.sv
// Shared KPN types and constants for the BCD display path.
// Holds data widths, the converter state enum and a digit-count helper.
package kpn_pkg;

  localparam int KPN_DATA_WIDTH = 16;
  localparam int KPN_BCD_DIGITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  // ceil(w * log10(2)) in fixed point
  function automatic int min_bcd_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bcd_serial_converter_if.sv
// FIFO-in / result-out bundle of the BCD converter.
// master is the converter, slave the FIFO plus display side.
interface bcd_serial_converter_if
  import kpn_pkg::*;
#(
  parameter int WIDTH  = KPN_DATA_WIDTH,
  parameter int DIGITS = KPN_BCD_DIGITS
) ();

  logic                  fifo_empty;
  logic [WIDTH-1:0]      entry_1;
  logic                  rd;
  logic [DIGITS*4-1:0]   output_1;
  logic                  valid;
  logic                  ack;
  logic                  busy;

  modport master (
    input  fifo_empty,
    input  entry_1,
    input  ack,
    output rd,
    output output_1,
    output valid,
    output busy
  );

  modport slave (
    output fifo_empty,
    output entry_1,
    output ack,
    input  rd,
    input  output_1,
    input  valid,
    input  busy
  );

endinterface

// File: rtl/bcd_serial_converter_digit_adjust.sv
// One double-dabble digit correction: +3 when the digit is 5 or more.
// Pure 4-bit arithmetic, no carry leaves the digit.
module bcd_digit_adjust (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter between the KPN FIFO and displays.
// One token per WIDTH shift cycles, result held until the next one.
module bcd_serial_converter
  import kpn_pkg::*;
#(
  parameter int WIDTH  = KPN_DATA_WIDTH,
  parameter int DIGITS = KPN_BCD_DIGITS
) (
  input  logic clk,
  input  logic rst_n,
  bcd_serial_converter_if.master bus
);

  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH + 1);

  if (DIGITS < min_bcd_digits(WIDTH)) begin : g_bad_digits
    $error("DIGITS too small for WIDTH");
  end

  bcd_state_t       state;
  logic [WIDTH-1:0] bin_q;
  logic [BW-1:0]    bcd_q;
  logic [CW-1:0]    cnt_q;

  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_nxt;
  logic [WIDTH-1:0] bin_nxt;
  logic             pop;
  logic             unused_adj_msb;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d (bcd_q[i*4 +: 4]),
      .q (bcd_adj[i*4 +: 4])
    );
  end

  // top bit always shifts out as 0 since max input fits
  assign unused_adj_msb = bcd_adj[BW-1];
  assign bcd_nxt = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
  assign bin_nxt = {bin_q[WIDTH-2:0], 1'b0};

  // pop from IDLE, or from DONE when the consumer acks
  assign pop = !bus.fifo_empty &&
               ((state == IDLE) ||
                (state == DONE && bus.ack));

  assign bus.rd   = pop;
  assign bus.busy = (state == SHIFT);

  // FSM and datapath: load, shift-add, publish result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bin_q        <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      bus.output_1 <= '0;
      bus.valid    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            bin_q <= bus.entry_1;
            bcd_q <= '0;
            cnt_q <= CW'(WIDTH);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_nxt;
          bin_q <= bin_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state        <= DONE;
            bus.output_1 <= bcd_nxt;
            bus.valid    <= 1'b1;
          end
        end
        DONE: begin
          if (bus.ack) begin
            bus.valid <= 1'b0;
            if (pop) begin
              bin_q <= bus.entry_1;
              bcd_q <= '0;
              cnt_q <= CW'(WIDTH);
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed and scoreboard bench for bcd_serial_converter.
// Bench owns a FIFO model driven from the test thread.
module tb_bcd_serial_converter;

  logic clk;
  logic rst_n;

  bcd_serial_converter_if bus ();

  bcd_serial_converter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vecs;
  int errs;
  int rd_total;
  int pops;
  logic [15:0] fifo_q[$];

  always @(posedge clk) begin
    if (bus.rd) rd_total <= rd_total + 1;
  end

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic update_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.entry_1 = (fifo_q.size() == 0) ? 16'h0 : fifo_q[0];
  endtask

  task automatic tick();
    @(negedge clk);
    while (pops < rd_total) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pops++;
    end
    update_fifo();
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    update_fifo();
    #1;
  endtask

  task automatic wait_rd(input string nm);
    int k;
    k = 0;
    while (!bus.rd && k < 20) begin
      tick();
      k++;
    end
    vecs++;
    if (bus.rd !== 1'b1) begin
      errs++;
      $display("FAIL %s rd_timeout got=%b want=1", nm, bus.rd);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ack = 1'b0;
    update_fifo();
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      vecs++;
      if ({bus.rd, bus.valid, bus.busy} !== 3'b000 ||
          bus.output_1 !== 20'h0) begin
        errs++;
        $display("FAIL reset_idle c%0d rd/valid/busy=%b%b%b out=%h want 000/00000",
                 i, bus.rd, bus.valid, bus.busy, bus.output_1);
      end
    end
  endtask

  task automatic test_single();
    push(16'd1234);
    wait_rd("single");
    for (int i = 1; i <= 17; i++) begin
      tick();
      vecs++;
      if (i < 17) begin
        if (bus.valid !== 1'b0 || bus.rd !== 1'b0) begin
          errs++;
          $display("FAIL single_latency T+%0d valid=%b rd=%b want 0/0",
                   i, bus.valid, bus.rd);
        end
      end else if (bus.valid !== 1'b1 || bus.output_1 !== 20'h01234) begin
        errs++;
        $display("FAIL single_result valid=%b out=%h want 1/01234",
                 bus.valid, bus.output_1);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      vecs++;
      if (bus.valid !== 1'b1 || bus.rd !== 1'b0 ||
          bus.output_1 !== 20'h01234) begin
        errs++;
        $display("FAIL single_hold c%0d valid=%b rd=%b out=%h want 1/0/01234",
                 i, bus.valid, bus.rd, bus.output_1);
      end
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    vecs++;
    if (bus.valid !== 1'b0 || bus.output_1 !== 20'h01234) begin
      errs++;
      $display("FAIL single_ack valid=%b out=%h want 0/01234",
               bus.valid, bus.output_1);
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] tok [4];
    logic [19:0] exp [4];
    tok = '{16'd0, 16'd9, 16'd10, 16'd65535};
    exp = '{20'h00000, 20'h00009, 20'h00010, 20'h65535};
    for (int n = 0; n < 4; n++) begin
      push(tok[n]);
      wait_rd("boundary");
      repeat (17) tick();
      vecs++;
      if (bus.valid !== 1'b1 || bus.output_1 !== exp[n]) begin
        errs++;
        $display("FAIL boundary tok=%0d valid=%b out=%h want 1/%h",
                 tok[n], bus.valid, bus.output_1, exp[n]);
      end
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    bus.ack = 1'b1;
    fifo_q.push_back(16'd100);
    fifo_q.push_back(16'd200);
    push(16'd300);
    wait_rd("b2b");
    for (int i = 1; i <= 51; i++) begin
      tick();
      if (i == 17 || i == 34 || i == 51) begin
        vecs++;
        if (bus.valid !== 1'b1 ||
            bus.output_1 !== to_bcd(100 * (i / 17)) ||
            bus.rd !== (i != 51)) begin
          errs++;
          $display("FAIL b2b T+%0d valid=%b rd=%b out=%h want 1/%b/%h",
                   i, bus.valid, bus.rd, bus.output_1,
                   (i != 51), to_bcd(100 * (i / 17)));
        end
      end else if (bus.rd !== 1'b0) begin
        vecs++;
        errs++;
        $display("FAIL b2b_rd T+%0d rd=%b want 0", i, bus.rd);
      end
    end
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    push(16'd4321);
    wait_rd("reset_mid");
    repeat (8) tick();
    rst_n = 1'b0;
    tick();
    vecs++;
    if ({bus.rd, bus.valid, bus.busy} !== 3'b000 ||
        bus.output_1 !== 20'h0) begin
      errs++;
      $display("FAIL reset_mid rd/valid/busy=%b%b%b out=%h want 000/00000",
               bus.rd, bus.valid, bus.busy, bus.output_1);
    end
    rst_n = 1'b1;
    tick();
    push(16'd55);
    wait_rd("after_reset");
    repeat (17) tick();
    vecs++;
    if (bus.valid !== 1'b1 || bus.output_1 !== 20'h00055) begin
      errs++;
      $display("FAIL after_reset valid=%b out=%h want 1/00055",
               bus.valid, bus.output_1);
    end
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic test_random();
    int exp_q[$];
    int pushed;
    int rises;
    int rd0;
    int budget;
    int v;
    logic prev_valid;
    pushed = 0;
    rises = 0;
    budget = 0;
    rd0 = rd_total;
    prev_valid = bus.valid;
    while (rises < 1000 && budget < 60000) begin
      tick();
      budget++;
      if (bus.valid && !prev_valid) begin
        rises++;
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL random_extra out=%h want no result", bus.output_1);
        end else begin
          v = exp_q.pop_front();
          if (bus.output_1 !== to_bcd(v)) begin
            errs++;
            $display("FAIL random tok=%0d out=%h want %h",
                     v, bus.output_1, to_bcd(v));
          end
        end
      end
      prev_valid = bus.valid;
      if (pushed < 1000 && fifo_q.size() < 3 &&
          $urandom_range(0, 3) == 0) begin
        v = (pushed % 97 == 0) ? 65535 : int'($urandom_range(0, 65535));
        exp_q.push_back(v);
        push(16'(v));
        pushed++;
      end
      bus.ack = ($urandom_range(0, 2) != 0);
    end
    bus.ack = 1'b0;
    vecs++;
    if (rises != 1000) begin
      errs++;
      $display("FAIL random_budget results=%0d want 1000", rises);
    end
    vecs++;
    if (rd_total - rd0 != rises) begin
      errs++;
      $display("FAIL random_rd_count rd=%0d want %0d",
               rd_total - rd0, rises);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rd_total = 0;
    pops = 0;
    rst_n = 1'b0;
    bus.ack = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.entry_1 = '0;
    test_reset();
    test_single();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
